voice_allocator: RTL and testbench

- Shares NUM_VOICES envelope/oscillator voices among a stream of note-on/note-off events from the CPU register block.
- Drives one gate per voice into the per-voice envelope generators and publishes the note number each voice plays.
- Sequences voice search, LRU tracking and optional voice stealing, respecting the envelope's sample_clock-rate gate sampling.

---
 rtl/voice_allocator.sv | 152 +++++++++++++++
 tb/tb_voice_allocator.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/voice_allocator.sv
// voice_allocator: shares NUM_VOICES envelope voices among note-on/note-off events
// Ports: clk/rst (async active-low) clock and reset; sample_clock per-sample strobe;
//   ev_valid/ev_ready/ev_on/ev_note event handshake; env_idle per-voice envelope silent;
//   gate per-voice envelope gate; voice_note packed note per voice; drop/steal one-clk pulses.
// Optional feature: define VOICE_STEAL_EN to steal the least recently used voice when none is free.
module voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int NOTE_BITS  = 7
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            sample_clock,
  input  logic                            ev_valid,
  output logic                            ev_ready,
  input  logic                            ev_on,
  input  logic [NOTE_BITS-1:0]            ev_note,
  input  logic [NUM_VOICES-1:0]           env_idle,
  output logic [NUM_VOICES-1:0]           gate,
  output logic [NUM_VOICES*NOTE_BITS-1:0] voice_note,
  output logic                            drop,
  output logic                            steal
);
  localparam int IW = $clog2(NUM_VOICES);
  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    APPLY
`ifdef VOICE_STEAL_EN
    , STEAL_WAIT
`endif
  } state_t;
  state_t                r_state, w_next;
  logic [IW-1:0]         r_idx, r_mi, r_fi, w_tgt;
  logic                  r_mf, r_ff, r_on, r_drop, r_steal;
  logic [NOTE_BITS-1:0]  r_evn;
  logic [NUM_VOICES-1:0] r_gate;
  logic [NOTE_BITS-1:0]  r_vnote [NUM_VOICES];
  logic [IW-1:0]         r_rank [NUM_VOICES];
  logic [IW-1:0]         w_rank_new [NUM_VOICES];
  logic                  w_accept, w_last, w_hit, w_free;
  assign ev_ready = r_state == IDLE;
  assign w_accept = ev_valid && ev_ready;
  assign w_last   = r_idx == IW'(NUM_VOICES - 1);
  assign w_hit    = r_gate[r_idx] && r_vnote[r_idx] == r_evn;
  assign w_free   = !r_gate[r_idx] && env_idle[r_idx];
  assign gate     = r_gate;
  assign drop     = r_drop;
  assign steal    = r_steal;
  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_vn
    assign voice_note[g*NOTE_BITS +: NOTE_BITS] = r_vnote[g];
  end
`ifdef VOICE_STEAL_EN
  logic [IW-1:0] r_oi;
  logic          r_sc;
  assign w_tgt = r_state == APPLY ? r_fi : r_oi;
`else
  logic w_unused;
  assign w_unused = sample_clock;
  assign w_tgt    = r_fi;
`endif
  // Move-to-front LRU: target becomes rank 0, everything younger than it ages by one.
  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++)
      w_rank_new[i] = (i == int'(w_tgt)) ? '0 : r_rank[i] + IW'(r_rank[i] < r_rank[w_tgt]);
  end
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && w_accept) w_next = SCAN;
    if (r_state == SCAN && w_last) w_next = APPLY;
`ifdef VOICE_STEAL_EN
    if (r_state == APPLY) w_next = (r_on && !r_mf && !r_ff) ? STEAL_WAIT : IDLE;
    if (r_state == STEAL_WAIT && sample_clock && r_sc) w_next = IDLE;
`else
    if (r_state == APPLY) w_next = IDLE;
`endif
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx   <= '0;
      r_mi    <= '0;
      r_fi    <= '0;
      r_mf    <= 1'b0;
      r_ff    <= 1'b0;
      r_on    <= 1'b0;
      r_evn   <= '0;
      r_drop  <= 1'b0;
      r_steal <= 1'b0;
      r_gate  <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_vnote[i] <= '0;
        r_rank[i]  <= IW'(i);
      end
`ifdef VOICE_STEAL_EN
      r_oi <= '0;
      r_sc <= 1'b0;
`endif
    end else begin
      r_drop  <= 1'b0;
      r_steal <= 1'b0;
      if (r_state == IDLE && w_accept) begin
        r_on  <= ev_on;
        r_evn <= ev_note;
        r_idx <= '0;
        r_mf  <= 1'b0;
        r_ff  <= 1'b0;
      end
      if (r_state == SCAN) begin
        r_idx <= r_idx + 1'b1;
        if (w_hit && !r_mf) begin
          r_mf <= 1'b1;
          r_mi <= r_idx;
        end
        if (w_free && !r_ff) begin
          r_ff <= 1'b1;
          r_fi <= r_idx;
        end
`ifdef VOICE_STEAL_EN
        if (r_rank[r_idx] == IW'(NUM_VOICES - 1)) r_oi <= r_idx;
`endif
      end
      if (r_state == APPLY) begin
        if (r_on && !r_mf && r_ff) begin
          r_gate[r_fi]  <= 1'b1;
          r_vnote[r_fi] <= r_evn;
          r_rank        <= w_rank_new;
        end else if (r_on && !r_mf) begin
`ifdef VOICE_STEAL_EN
          r_gate[r_oi] <= 1'b0;
          r_steal      <= 1'b1;
          r_sc         <= 1'b0;
`else
          r_drop <= 1'b1;
`endif
        end else if (!r_on && r_mf) r_gate[r_mi] <= 1'b0;
      end
`ifdef VOICE_STEAL_EN
      // Gate stays low across two sample strobes so the envelope is sure to see the release.
      if (r_state == STEAL_WAIT && sample_clock) begin
        r_sc <= 1'b1;
        if (r_sc) begin
          r_gate[r_oi]  <= 1'b1;
          r_vnote[r_oi] <= r_evn;
          r_rank        <= w_rank_new;
        end
      end
`endif
    end
  end
endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: randomized and directed checks of voice_allocator against a queue-based LRU model
module tb_voice_allocator;
  localparam int N  = 4;
  localparam int NB = 7;
  logic              clk = 0, rst = 0, sample_clock = 0, ev_valid = 0, ev_on = 0;
  logic [NB-1:0]     ev_note = '0;
  logic [N-1:0]      env_idle = '1;
  logic              ev_ready, drop, steal;
  logic [N-1:0]      gate;
  logic [N*NB-1:0]   voice_note;
  int                tests = 0, fails = 0;
  bit                m_gate [N];
  logic [NB-1:0]     m_note [N];
  int                lru [$];
  voice_allocator #(.NUM_VOICES(N), .NOTE_BITS(NB)) dut (
    .clk(clk), .rst(rst), .sample_clock(sample_clock), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_on(ev_on), .ev_note(ev_note), .env_idle(env_idle), .gate(gate), .voice_note(voice_note),
    .drop(drop), .steal(steal)
  );
  always #5 clk = ~clk;
  initial begin
    @(posedge clk);
    forever begin
      repeat (6) @(posedge clk);
      #1 sample_clock = 1;
      @(posedge clk);
      #1 sample_clock = 0;
    end
  end
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic void m_reset();
    lru = {};
    for (int i = 0; i < N; i++) begin
      m_gate[i] = 0;
      m_note[i] = '0;
      lru.push_back(i);
    end
  endfunction
  function automatic void touch(int v);
    foreach (lru[i]) if (lru[i] == v) begin
      lru.delete(i);
      break;
    end
    lru.push_front(v);
  endfunction
  function automatic logic [N-1:0] m_gates();
    logic [N-1:0] g;
    for (int i = 0; i < N; i++) g[i] = m_gate[i];
    return g;
  endfunction
  function automatic logic [N*NB-1:0] m_notes();
    logic [N*NB-1:0] b;
    for (int i = 0; i < N; i++) b[i*NB +: NB] = m_note[i];
    return b;
  endfunction
  task automatic check_reset();
    chk("rst_ready", ev_ready, 1);
    chk("rst_gate", gate, 0);
    chk("rst_notes", voice_note, 0);
    chk("rst_pulses", {drop, steal}, 0);
  endtask
  // Issue one event; rst_at >= 0 pulls reset that many cycles after acceptance.
  task automatic send(bit on, logic [NB-1:0] note, int rst_at = -1);
    int match = -1, free = -1, victim = 0, k = 0, nd = 0, ns = 0;
    bit exp_drop = 0, exp_steal = 0, low_seen = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (m_gate[i] && m_note[i] == note) match = i;
      if (!m_gate[i] && env_idle[i]) free = i;
    end
    chk("ready_before", ev_ready, 1);
    ev_valid = 1;
    ev_on    = on;
    ev_note  = note;
    @(posedge clk);
    #1;
    ev_valid = 0;
    ev_on    = 1'($urandom);
    ev_note  = NB'($urandom);
    if (on && match < 0 && free < 0) begin
`ifdef VOICE_STEAL_EN
      exp_steal = 1;
      victim    = lru[$];
`else
      exp_drop = 1;
`endif
    end
    while (!ev_ready && k < 300) begin
      if (k == rst_at) begin
        rst = 0;
        #1;
        check_reset();
        @(negedge clk);
        rst = 1;
        @(posedge clk);
        #1;
        m_reset();
        return;
      end
      nd += drop;
      ns += steal;
      if (!gate[victim]) low_seen = 1;
      @(posedge clk);
      #1;
      k++;
    end
    nd += drop;
    ns += steal;
    chk("timeout", k < 300, 1);
    if (on && match < 0 && free >= 0) begin
      m_gate[free] = 1;
      m_note[free] = note;
      touch(free);
    end else if (exp_steal) begin
      m_note[victim] = note;
      touch(victim);
      chk("steal_gate_low", low_seen, 1);
    end else if (!on && match >= 0) m_gate[match] = 0;
    if (!exp_steal) chk("latency", k, N + 1);
    chk("gate", gate, m_gates());
    chk("notes", voice_note, m_notes());
    chk("drop", nd, exp_drop);
    chk("steal", ns, exp_steal);
    @(posedge clk);
    #1;
    chk("pulse_end", {drop, steal}, 0);
  endtask
  initial begin
    m_reset();
    #12;
    check_reset();
    rst = 1;
    @(posedge clk);
    #1;
    send(1, 60);
    chk("first_gate", gate, 4'b0001);
    send(1, 62);
    send(1, 64);
    send(1, 67);
    chk("four_gate", gate, 4'b1111);
    send(0, 62);
    chk("off_gate", gate, 4'b1101);
    send(1, 62);
    send(1, 70);
`ifdef VOICE_STEAL_EN
    send(1, 72);
    send(1, 74, N + 3);
    send(1, 60);
    chk("after_steal_rst", gate, 4'b0001);
`endif
    send(1, 61, 2);
    send(1, 60);
    send(1, 60);
    chk("dup_gate", gate, 4'b0001);
    for (int n = 0; n < 150; n++) begin
      env_idle = N'($urandom);
      send($urandom_range(0, 9) < 6, NB'(60 + $urandom_range(0, 7)));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
